// File: rtl/bsg_and_mask_burst_feeder.sv
// Operand feeder for the 16-bit AND block: latches a mask per burst and
// pairs it with each data beat in a 2-entry FIFO.
module bsg_and_mask_burst_feeder #(
  parameter int width_p     = 16,
  parameter int len_width_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   mask_v_i,
  input  logic [width_p-1:0]     mask_i,
  input  logic [len_width_p-1:0] len_i,
  output logic                   mask_ready_o,
  input  logic                   data_v_i,
  input  logic [width_p-1:0]     data_i,
  output logic                   data_ready_o,
  output logic                   v_o,
  output logic [width_p-1:0]     a_o,
  output logic [width_p-1:0]     b_o,
  output logic                   last_o,
  input  logic                   yumi_i
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic [len_width_p-1:0] one_lp = 1;

  state_e                   state_q, state_d;
  logic [width_p-1:0]       mask_q, mask_d;
  logic [len_width_p-1:0]   cnt_q, cnt_d;
  logic [width_p-1:0]       dmem_q [2];
  logic [width_p-1:0]       dmem_d [2];
  logic [width_p-1:0]       mmem_q [2];
  logic [width_p-1:0]       mmem_d [2];
  logic [1:0]               lmem_q, lmem_d;
  logic                     wptr_q, wptr_d;
  logic                     rptr_q, rptr_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic                     enq, deq, head;

  assign mask_ready_o = (state_q == IDLE);
  assign data_ready_o = (state_q == BURST) & ~full_q;
  assign enq          = data_v_i & data_ready_o;
  assign deq          = yumi_i & ~empty_q;

  // When empty, show the slot just popped so outputs hold their last value
  assign head   = empty_q ? ~rptr_q : rptr_q;
  assign v_o    = ~empty_q;
  assign a_o    = dmem_q[head];
  assign b_o    = mmem_q[head];
  assign last_o = lmem_q[head];

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    dmem_d  = dmem_q;
    mmem_d  = mmem_q;
    lmem_d  = lmem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    full_d  = full_q;
    empty_d = empty_q;
    unique case (state_q)
      IDLE: begin
        if (mask_v_i) begin
          mask_d  = mask_i;
          cnt_d   = len_i;
          state_d = BURST;
        end
      end
      BURST: begin
        if (enq) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - one_lp;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enq) begin
      dmem_d[wptr_q] = data_i;
      mmem_d[wptr_q] = mask_q;
      lmem_d[wptr_q] = (cnt_q == '0);
      wptr_d         = ~wptr_q;
    end
    if (deq) rptr_d = ~rptr_q;
    if (enq & ~deq) begin
      empty_d = 1'b0;
      full_d  = (~wptr_q == rptr_q);
    end else if (deq & ~enq) begin
      full_d  = 1'b0;
      empty_d = (~rptr_q == wptr_q);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      cnt_q   <= '0;
      dmem_q  <= '{default: '0};
      mmem_q  <= '{default: '0};
      lmem_q  <= '0;
      wptr_q  <= 1'b0;
      rptr_q  <= 1'b0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      dmem_q  <= dmem_d;
      mmem_q  <= mmem_d;
      lmem_q  <= lmem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
